// File: rtl/alu_pkg.sv
// Shared types and the command legality/operand-need table for the ALU operand collector.
package alu_pkg;

    localparam int ALU_CMD_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_A = 2'd1,
        WAIT_B = 2'd2
    } coll_state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_NOOP = 2'b01,
        ERR_TMO  = 2'b10,
        ERR_ILL  = 2'b11
    } err_code_t;

    // bit0 = opa needed, bit1 = opb needed; 00 marks an illegal command
    function automatic logic [1:0] cmd_need(input logic mode, input logic [ALU_CMD_W-1:0] cmd);
        logic [1:0] need;
        need = 2'b00;
        if (mode) begin
            case (cmd)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10: need = 2'b11;
                4'd4, 4'd5:                                need = 2'b01;
                4'd6, 4'd7:                                need = 2'b10;
                default:                                   need = 2'b00;
            endcase
        end else begin
            case (cmd)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13: need = 2'b11;
                4'd6, 4'd8, 4'd9:                                 need = 2'b01;
                4'd7, 4'd10, 4'd11:                               need = 2'b10;
                default:                                          need = 2'b00;
            endcase
        end
        return need;
    endfunction

endpackage

// File: rtl/alu_operand_collector_if.sv
// Request/issue bundle between the bus side (master) and the operand collector (slave).
interface alu_operand_collector_if #(
    parameter int WIDTH = 8,
    parameter int CMD_W = 4,
    parameter int CNT_W = 5
);
    logic             ce;
    logic             mode;
    logic [CMD_W-1:0] cmd;
    logic [1:0]       inp_valid;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin;

    logic             issue_valid;
    logic             issue_mode;
    logic [CMD_W-1:0] issue_cmd;
    logic [WIDTH-1:0] issue_opa;
    logic [WIDTH-1:0] issue_opb;
    logic             issue_cin;
    logic             err;
    logic [1:0]       err_code;
    logic             busy;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        output ce, mode, cmd, inp_valid, opa, opb, cin,
        input  issue_valid, issue_mode, issue_cmd, issue_opa, issue_opb, issue_cin,
        input  err, err_code, busy, wait_cnt
    );

    modport slave (
        input  ce, mode, cmd, inp_valid, opa, opb, cin,
        output issue_valid, issue_mode, issue_cmd, issue_opa, issue_opb, issue_cin,
        output err, err_code, busy, wait_cnt
    );
endinterface

// File: rtl/alu_wait_counter.sv
// Clock-enabled wait counter with clear and a terminal-count flag at TIMEOUT-1.
module alu_wait_counter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ce) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_operand_collector.sv
// Collects cmd/mode/cin and two operands that may arrive on different cycles,
// then issues one registered complete operation or a coded error pulse.
//   state  | meaning
//   IDLE   | ready for a new operation
//   WAIT_A | cmd and opb held, waiting for opa
//   WAIT_B | cmd and opa held, waiting for opb
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CMD_W   = ALU_CMD_W,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_operand_collector_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_WAIT_A = WAIT_A;
    localparam logic [1:0] S_WAIT_B = WAIT_B;

    logic [1:0]       state_d, state_q;
    logic             mode_d, mode_q;
    logic [CMD_W-1:0] cmd_d, cmd_q;
    logic             cin_d, cin_q;
    logic [WIDTH-1:0] opa_d, opa_q;
    logic [WIDTH-1:0] opb_d, opb_q;

    logic             issue_valid_d, issue_valid_q;
    logic             issue_mode_d, issue_mode_q;
    logic [CMD_W-1:0] issue_cmd_d, issue_cmd_q;
    logic [WIDTH-1:0] issue_opa_d, issue_opa_q;
    logic [WIDTH-1:0] issue_opb_d, issue_opb_q;
    logic             issue_cin_d, issue_cin_q;
    logic             err_d, err_q;
    logic [1:0]       err_code_d, err_code_q;

    logic [ALU_CMD_W-1:0] cmd_base;
    logic [1:0]           need;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic                 cnt_tc;
    logic [CNT_W-1:0]     cnt;

    alu_wait_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (bus.ce),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // Codes that do not survive truncation to the table width are illegal
    always_comb begin
        cmd_base = ALU_CMD_W'(bus.cmd);
        need     = 2'b00;
        if (CMD_W'(cmd_base) == bus.cmd) begin
            need = cmd_need(bus.mode, cmd_base);
        end
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cmd_d         = cmd_q;
        cin_d         = cin_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        issue_valid_d = 1'b0;
        issue_mode_d  = issue_mode_q;
        issue_cmd_d   = issue_cmd_q;
        issue_opa_d   = issue_opa_q;
        issue_opb_d   = issue_opb_q;
        issue_cin_d   = issue_cin_q;
        err_d         = 1'b0;
        err_code_d    = ERR_NONE;
        cnt_clr       = 1'b1;
        cnt_inc       = 1'b0;

        if (bus.ce) begin
            case (state_q)
                S_IDLE: begin
                    if (need == 2'b00) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILL;
                    end else if (bus.inp_valid == 2'b00) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NOOP;
                    end else if ((bus.inp_valid & need) == need) begin
                        issue_valid_d = 1'b1;
                        issue_mode_d  = bus.mode;
                        issue_cmd_d   = bus.cmd;
                        issue_cin_d   = bus.cin;
                        issue_opa_d   = bus.opa;
                        issue_opb_d   = bus.opb;
                    end else begin
                        mode_d = bus.mode;
                        cmd_d  = bus.cmd;
                        cin_d  = bus.cin;
                        if (bus.inp_valid[0]) begin
                            opa_d   = bus.opa;
                            state_d = S_WAIT_B;
                        end else begin
                            opb_d   = bus.opb;
                            state_d = S_WAIT_A;
                        end
                    end
                end
                S_WAIT_A, S_WAIT_B: begin
                    // An arrival on the terminal-count cycle still issues
                    if ((state_q == S_WAIT_A) ? bus.inp_valid[0] : bus.inp_valid[1]) begin
                        issue_valid_d = 1'b1;
                        issue_mode_d  = mode_q;
                        issue_cmd_d   = cmd_q;
                        issue_cin_d   = cin_q;
                        issue_opa_d   = (state_q == S_WAIT_A) ? bus.opa : opa_q;
                        issue_opb_d   = (state_q == S_WAIT_B) ? bus.opb : opb_q;
                        state_d       = S_IDLE;
                    end else if (cnt_tc) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TMO;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_clr = 1'b0;
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            cmd_q         <= '0;
            cin_q         <= 1'b0;
            opa_q         <= '0;
            opb_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_mode_q  <= 1'b0;
            issue_cmd_q   <= '0;
            issue_opa_q   <= '0;
            issue_opb_q   <= '0;
            issue_cin_q   <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cmd_q         <= cmd_d;
            cin_q         <= cin_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            issue_valid_q <= issue_valid_d;
            issue_mode_q  <= issue_mode_d;
            issue_cmd_q   <= issue_cmd_d;
            issue_opa_q   <= issue_opa_d;
            issue_opb_q   <= issue_opb_d;
            issue_cin_q   <= issue_cin_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_mode  = issue_mode_q;
    assign bus.issue_cmd   = issue_cmd_q;
    assign bus.issue_opa   = issue_opa_q;
    assign bus.issue_opb   = issue_opb_q;
    assign bus.issue_cin   = issue_cin_q;
    assign bus.err         = err_q;
    assign bus.err_code    = err_code_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.wait_cnt    = cnt;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Randomised and directed checks of the operand collector against a transaction-level model.
module tb_alu_operand_collector;

    localparam int WIDTH   = 8;
    localparam int CMD_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    logic clk = 1'b0;
    logic rst_n;

    alu_operand_collector_if #(.WIDTH(WIDTH), .CMD_W(CMD_W), .CNT_W(CNT_W)) bus ();

    alu_operand_collector #(
        .WIDTH   (WIDTH),
        .CMD_W   (CMD_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // operand need per command: 3 = both, 1 = opa only, 2 = opb only, 0 = illegal
    int need_ar [16] = '{3, 3, 3, 3, 1, 1, 2, 2, 3, 3, 3, 0, 0, 0, 0, 0};
    int need_lg [16] = '{3, 3, 3, 3, 3, 3, 1, 2, 1, 1, 2, 2, 3, 3, 0, 0};

    bit             model_live = 1'b0;
    bit             pending    = 1'b0;
    bit             want_a     = 1'b0;
    int             waited     = 0;
    logic           h_mode, h_cin;
    logic [3:0]     h_cmd;
    logic [7:0]     h_opa, h_opb;
    logic           exp_iv, exp_err, exp_zero;
    logic [1:0]     exp_code;
    logic           exp_mode, exp_cin;
    logic [3:0]     exp_cmd;
    logic [7:0]     exp_opa, exp_opb;

    task automatic model_issue(input logic m, input logic [3:0] c, input logic ci,
                               input logic [7:0] a, input logic [7:0] b);
        exp_iv   = 1'b1;
        exp_mode = m;
        exp_cmd  = c;
        exp_cin  = ci;
        exp_opa  = a;
        exp_opb  = b;
    endtask

    task automatic model_step();
        int         need;
        logic [1:0] iv;
        exp_iv   = 1'b0;
        exp_err  = 1'b0;
        exp_code = 2'b00;
        exp_zero = 1'b0;
        iv       = bus.inp_valid;
        if (!rst_n) begin
            pending    = 1'b0;
            waited     = 0;
            exp_zero   = 1'b1;
            model_live = 1'b1;
        end else if (bus.ce) begin
            need = bus.mode ? need_ar[bus.cmd] : need_lg[bus.cmd];
            if (!pending) begin
                if (need == 0) begin
                    exp_err  = 1'b1;
                    exp_code = 2'b11;
                end else if (iv == 2'b00) begin
                    exp_err  = 1'b1;
                    exp_code = 2'b01;
                end else if ((int'(iv) & need) == need) begin
                    model_issue(bus.mode, bus.cmd, bus.cin, bus.opa, bus.opb);
                end else begin
                    pending = 1'b1;
                    want_a  = !iv[0];
                    h_mode  = bus.mode;
                    h_cmd   = bus.cmd;
                    h_cin   = bus.cin;
                    h_opa   = bus.opa;
                    h_opb   = bus.opb;
                    waited  = 0;
                end
            end else if (want_a ? iv[0] : iv[1]) begin
                model_issue(h_mode, h_cmd, h_cin, want_a ? bus.opa : h_opa, want_a ? h_opb : bus.opb);
                pending = 1'b0;
                waited  = 0;
            end else if (waited == TIMEOUT - 1) begin
                exp_err  = 1'b1;
                exp_code = 2'b10;
                pending  = 1'b0;
                waited   = 0;
            end else begin
                waited++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_live) begin
            chk("issue_valid", bus.issue_valid, exp_iv);
            chk("err", bus.err, exp_err);
            chk("err_code", bus.err_code, exp_code);
            chk("busy", bus.busy, pending);
            chk("wait_cnt", bus.wait_cnt, waited);
            chk("pulse_excl", bus.issue_valid & bus.err, 0);
            if (exp_iv) begin
                chk("issue_mode", bus.issue_mode, exp_mode);
                chk("issue_cmd", bus.issue_cmd, exp_cmd);
                chk("issue_cin", bus.issue_cin, exp_cin);
                chk("issue_opa", bus.issue_opa, exp_opa);
                chk("issue_opb", bus.issue_opb, exp_opb);
            end else if (exp_zero) begin
                chk("rst_issue_fields",
                    {bus.issue_mode, bus.issue_cmd, bus.issue_cin, bus.issue_opa, bus.issue_opb}, 0);
            end
        end
    end

    task automatic set(input logic ce, input logic mode, input logic [3:0] cmd, input logic [1:0] iv,
                       input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.ce        = ce;
        bus.mode      = mode;
        bus.cmd       = cmd;
        bus.inp_valid = iv;
        bus.opa       = a;
        bus.opb       = b;
        bus.cin       = cin;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int busy_cycles;
    int early;
    int ones;
    int fired_at;
    int pz;

    initial begin
        rst_n = 1'b0;
        set(0, 0, 0, 2'b00, 0, 0, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("init_busy", bus.busy, 0);
        chk("init_err", bus.err, 0);

        // complete operation in one cycle
        set(1, 1, 4'd0, 2'b11, 8'h12, 8'h34, 0);
        step();
        chk("t2_iv", bus.issue_valid, 1);
        chk("t2_opa", bus.issue_opa, 8'h12);
        chk("t2_opb", bus.issue_opb, 8'h34);
        set(0, 0, 0, 2'b00, 0, 0, 0);
        step();
        chk("t2_pulse_end", bus.issue_valid, 0);

        // opb arrives 5 cycles after opa; cmd/mode changes while waiting are ignored
        set(1, 1, 4'd0, 2'b01, 8'hAA, 8'h00, 1);
        step();
        busy_cycles = 0;
        if (bus.busy) busy_cycles++;
        for (int i = 0; i < 4; i++) begin
            set(1, 0, 4'hF, 2'b00, 8'h11, 8'h22, 0);
            step();
            if (bus.busy) busy_cycles++;
        end
        set(1, 0, 4'hF, 2'b10, 8'h33, 8'h55, 0);
        step();
        chk("t3_busy_cycles", busy_cycles, 5);
        chk("t3_iv", bus.issue_valid, 1);
        chk("t3_opa", bus.issue_opa, 8'hAA);
        chk("t3_opb", bus.issue_opb, 8'h55);
        chk("t3_cmd_locked", bus.issue_cmd, 4'd0);
        chk("t3_mode_locked", bus.issue_mode, 1);
        chk("t3_cin_locked", bus.issue_cin, 1);

        // timeout while waiting for opa
        set(1, 1, 4'd0, 2'b10, 8'h00, 8'h77, 0);
        step();
        early = 0;
        for (int i = 0; i < 15; i++) begin
            set(1, 1, 4'd0, 2'b00, 8'h00, 8'h00, 0);
            step();
            if (bus.err) early++;
        end
        chk("t4_no_early_err", early, 0);
        chk("t4_wait_at_tc", bus.wait_cnt, 15);
        step();
        chk("t4_err", bus.err, 1);
        chk("t4_code", bus.err_code, 2'b10);
        chk("t4_idle", bus.busy, 0);
        chk("t4_cnt_clr", bus.wait_cnt, 0);

        // operand arriving on the terminal-count cycle wins
        set(1, 1, 4'd0, 2'b10, 8'h00, 8'h77, 0);
        step();
        for (int i = 0; i < 15; i++) begin
            set(1, 1, 4'd0, 2'b00, 8'h00, 8'h00, 0);
            step();
        end
        set(1, 1, 4'd0, 2'b01, 8'h99, 8'h00, 0);
        step();
        chk("t4b_iv", bus.issue_valid, 1);
        chk("t4b_no_err", bus.err, 0);
        chk("t4b_opa", bus.issue_opa, 8'h99);
        chk("t4b_opb", bus.issue_opb, 8'h77);

        // ce gating during a wait
        set(1, 1, 4'd0, 2'b01, 8'h5A, 8'h00, 0);
        step();
        ones     = 0;
        fired_at = -1;
        for (int i = 0; i < 40 && fired_at < 0; i++) begin
            set(logic'(i % 2), 1, 4'd0, 2'b00, 8'h00, 8'h00, 0);
            step();
            if (i % 2 == 1) ones++;
            if (bus.err) fired_at = ones;
            else chk("t5_wait_cnt", bus.wait_cnt, ones);
        end
        chk("t5_fired_at", fired_at, 16);

        // no-operand and illegal-command errors
        set(1, 1, 4'd0, 2'b00, 8'h00, 8'h00, 0);
        step();
        chk("t6_noop_err", bus.err, 1);
        chk("t6_noop_code", bus.err_code, 2'b01);
        set(1, 0, 4'd15, 2'b11, 8'h01, 8'h02, 0);
        step();
        chk("t6_ill_err", bus.err, 1);
        chk("t6_ill_code", bus.err_code, 2'b11);
        chk("t6_ill_no_issue", bus.issue_valid, 0);

        // reset in the middle of WAIT_B drops the operation silently
        set(1, 1, 4'd0, 2'b01, 8'hC3, 8'h00, 1);
        step();
        chk("t1_busy_before", bus.busy, 1);
        set(1, 1, 4'd0, 2'b00, 8'h00, 8'h00, 0);
        rst_n = 1'b0;
        step();
        step();
        chk("t1_busy", bus.busy, 0);
        chk("t1_err", bus.err, 0);
        chk("t1_iv", bus.issue_valid, 0);
        chk("t1_wait_cnt", bus.wait_cnt, 0);
        chk("t1_issue_opa", bus.issue_opa, 0);
        rst_n = 1'b1;
        set(0, 0, 0, 2'b00, 0, 0, 0);
        step();
        chk("t1_after_err", bus.err, 0);

        // random traffic
        pz = 70;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) pz = $urandom_range(40, 95);
            rst_n = ($urandom_range(0, 299) != 0);
            set(($urandom_range(0, 99) < 85), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 99) < pz) ? 2'b00 : 2'($urandom_range(1, 3)),
                8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            step();
        end
        rst_n = 1'b1;
        set(0, 0, 0, 2'b00, 0, 0, 0);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
